// File: rtl/cva6_tile_rst_ctrl_if.sv
// Hart-facing signal bundle of the tile reset controller: the asynchronous
// interrupt/debug lines coming into the tile and the synchronised, gated copies
// plus per-hart reset going out to the harts.
interface cva6_tile_rst_ctrl_if #(
  parameter int unsigned NrHarts    = 1,
  parameter int unsigned NrIrqLines = 2
);
  logic [NrHarts*NrIrqLines-1:0] irq_i;
  logic [NrHarts-1:0]            ipi_i;
  logic [NrHarts-1:0]            time_irq_i;
  logic [NrHarts-1:0]            debug_req_i;

  logic [NrHarts-1:0]            hart_rst_no;
  logic [NrHarts*NrIrqLines-1:0] irq_o;
  logic [NrHarts-1:0]            ipi_o;
  logic [NrHarts-1:0]            time_irq_o;
  logic [NrHarts-1:0]            debug_req_o;

  // Platform side: drives the raw lines, observes what reaches the harts.
  modport master (
    output irq_i, ipi_i, time_irq_i, debug_req_i,
    input  hart_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o
  );

  // Reset controller side.
  modport slave (
    input  irq_i, ipi_i, time_irq_i, debug_req_i,
    output hart_rst_no, irq_o, ipi_o, time_irq_o, debug_req_o
  );
endinterface

// File: rtl/cva6_tile_rst_ctrl.sv
// Per-tile reset sequencer and interrupt synchroniser for multi-hart CVA6 tiles.
// Holds all harts in reset during SRAM init (optionally also until the L1.5
// wake-up interrupt), releases them one by one with a stagger, supports a
// per-hart soft reset, and synchronises/gates every async interrupt line.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT_SRAM  | counting SRAM init cycles, all harts held in reset
// WAIT_INT   | init done, waiting for the L1.5 wake-up interrupt
// RELEASE    | releasing harts one at a time, StaggerCycles apart
// RUN        | all harts released; only rst_ni leaves this state
module cva6_tile_rst_ctrl #(
  parameter int unsigned NrHarts       = 1,
  parameter int unsigned NrIrqLines    = 2,
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned WakeCycles    = 32768,
  parameter int unsigned StaggerCycles = 0,
  parameter int unsigned WakeOnIntEn   = 0,
  parameter int unsigned SoftRstCycles = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wake_int_i,
  input  logic [NrHarts-1:0]       soft_rst_req_i,
  cva6_tile_rst_ctrl_if.slave      hart_if,
  output logic                     ready_o,
  output logic [1:0]               state_o
);

  localparam logic [1:0] ST_WAIT_SRAM = 2'd0;
  localparam logic [1:0] ST_WAIT_INT  = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int unsigned WakeW = $clog2(WakeCycles + 1);
  localparam int unsigned IdxW  = (NrHarts > 1) ? $clog2(NrHarts) : 1;
  localparam int unsigned StagW = (StaggerCycles > 0) ? $clog2(StaggerCycles + 1) : 1;
  localparam int unsigned SoftW = $clog2(SoftRstCycles + 1);
  // Per hart: NrIrqLines level IRQs, then ipi, time and debug.
  localparam int unsigned SyncW = NrIrqLines + 3;

  localparam logic [WakeW-1:0]   WakeLast  = WakeW'(WakeCycles - 1);
  localparam logic [WakeW-1:0]   WakeMax   = WakeW'(WakeCycles);
  localparam logic [IdxW-1:0]    IdxLast   = IdxW'(NrHarts - 1);
  localparam logic [StagW-1:0]   StagLoad  = StagW'(StaggerCycles);
  localparam logic [SoftW-1:0]   SoftLoad  = SoftW'(SoftRstCycles);
  localparam logic [NrHarts-1:0] RelOne    = NrHarts'(1);

  logic [1:0]         state_q, state_d;
  logic [WakeW-1:0]   wake_cnt_q;
  logic               int_seen_q;
  logic [IdxW-1:0]    idx_q;
  logic [StagW-1:0]   stag_cnt_q;
  logic [NrHarts-1:0] rel_q;
  logic               wake_ok;
  logic               rel_fire;

  // An interrupt seen earlier (int_seen_q) or right now both count as wake-up.
  assign wake_ok  = (WakeOnIntEn == 0) || int_seen_q || wake_int_i;
  // A hart is released in RELEASE whenever the stagger counter has drained.
  assign rel_fire = (state_q == ST_RELEASE) && (stag_cnt_q == '0);

  // Next-state logic of the sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SRAM: begin
        if (wake_cnt_q == WakeLast) begin
          state_d = wake_ok ? ST_RELEASE : ST_WAIT_INT;
        end
      end
      ST_WAIT_INT: begin
        if (wake_int_i) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rel_fire && (idx_q == IdxLast)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT_SRAM;
    end else begin
      state_q <= state_d;
    end
  end

  // SRAM init counter, saturating so it cannot wrap back into the compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wake_cnt_q <= '0;
    end else if ((state_q == ST_WAIT_SRAM) && (wake_cnt_q != WakeMax)) begin
      wake_cnt_q <= wake_cnt_q + 1'b1;
    end
  end

  // Sticky record of a wake-up interrupt so an early one is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_seen_q <= 1'b0;
    end else if (wake_int_i) begin
      int_seen_q <= 1'b1;
    end
  end

  // Staggered release: release hart idx_q, then drain the stagger counter
  // before releasing the next one on the cycle after it reaches zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rel_q      <= '0;
      idx_q      <= '0;
      stag_cnt_q <= '0;
    end else if (state_q == ST_RELEASE) begin
      if (stag_cnt_q != '0) begin
        stag_cnt_q <= stag_cnt_q - 1'b1;
      end else begin
        rel_q <= rel_q | (RelOne << idx_q);
        if (idx_q != IdxLast) begin
          idx_q      <= idx_q + 1'b1;
          stag_cnt_q <= StagLoad;
        end
      end
    end
  end

  for (genvar h = 0; h < NrHarts; h++) begin : g_hart
    logic                             soft_req;
    logic [SoftW-1:0]                 soft_cnt_q;
    logic [SyncStages-1:0]            rst_sync_q;
    logic [SyncW-1:0]                 async_in;
    logic [SyncStages-1:0][SyncW-1:0] sync_q;
    logic [SyncW-1:0]                 gated;

    // A soft reset only means something once the hart has been released.
    assign soft_req = soft_rst_req_i[h] & rel_q[h];

    // Soft-reset hold counter; a new request reloads it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        soft_cnt_q <= '0;
      end else if (soft_req) begin
        soft_cnt_q <= SoftLoad;
      end else if (soft_cnt_q != '0) begin
        soft_cnt_q <= soft_cnt_q - 1'b1;
      end
    end

    // Reset release chain; a soft request drops the hart on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rst_sync_q <= '0;
      end else if (soft_req) begin
        rst_sync_q <= '0;
      end else begin
        rst_sync_q <= {rst_sync_q[SyncStages-2:0], rel_q[h] & (soft_cnt_q == '0)};
      end
    end

    assign hart_if.hart_rst_no[h] = rst_sync_q[SyncStages-1];

    assign async_in = {hart_if.debug_req_i[h], hart_if.time_irq_i[h], hart_if.ipi_i[h],
                       hart_if.irq_i[h*NrIrqLines +: NrIrqLines]};

    // Synchronisers for all async interrupt and debug lines of this hart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SyncStages-2:0], async_in};
      end
    end

    // A hart in reset must never see a pending interrupt or debug request.
    assign gated = sync_q[SyncStages-1] & {SyncW{rst_sync_q[SyncStages-1]}};

    assign hart_if.irq_o[h*NrIrqLines +: NrIrqLines] = gated[NrIrqLines-1:0];
    assign hart_if.ipi_o[h]       = gated[NrIrqLines];
    assign hart_if.time_irq_o[h]  = gated[NrIrqLines+1];
    assign hart_if.debug_req_o[h] = gated[NrIrqLines+2];
  end

  assign ready_o = &hart_if.hart_rst_no;
  assign state_o = state_q;

endmodule

// File: tb/tb_cva6_tile_rst_ctrl.sv
// Bench for cva6_tile_rst_ctrl: five instances with different parameter sets
// run in parallel. Stimulus pushes the expected output changes (edge, value)
// into per-instance queues; a monitor pops and compares on every change.
module tb_cva6_tile_rst_ctrl;

  typedef struct {
    int          edge_n;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rst_n_v = '1;
  logic       wake_a, wake_b, wake_c, wake_d, wake_e;
  logic [0:0] soft_a, soft_c, soft_d;
  logic [3:0] soft_b;
  logic [1:0] soft_e;
  logic       ready_a, ready_b, ready_c, ready_d, ready_e;
  logic [1:0] state_a, state_b, state_c, state_d, state_e;

  cva6_tile_rst_ctrl_if #(.NrHarts(1), .NrIrqLines(2)) if_a ();
  cva6_tile_rst_ctrl_if #(.NrHarts(4), .NrIrqLines(2)) if_b ();
  cva6_tile_rst_ctrl_if #(.NrHarts(1), .NrIrqLines(2)) if_c ();
  cva6_tile_rst_ctrl_if #(.NrHarts(1), .NrIrqLines(2)) if_d ();
  cva6_tile_rst_ctrl_if #(.NrHarts(2), .NrIrqLines(2)) if_e ();

  cva6_tile_rst_ctrl u_a (
    .clk_i(clk), .rst_ni(rst_n_v[0]), .wake_int_i(wake_a), .soft_rst_req_i(soft_a),
    .hart_if(if_a), .ready_o(ready_a), .state_o(state_a));

  cva6_tile_rst_ctrl #(.NrHarts(4), .WakeCycles(16), .StaggerCycles(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n_v[1]), .wake_int_i(wake_b), .soft_rst_req_i(soft_b),
    .hart_if(if_b), .ready_o(ready_b), .state_o(state_b));

  cva6_tile_rst_ctrl #(.WakeCycles(16), .WakeOnIntEn(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n_v[2]), .wake_int_i(wake_c), .soft_rst_req_i(soft_c),
    .hart_if(if_c), .ready_o(ready_c), .state_o(state_c));

  cva6_tile_rst_ctrl #(.WakeCycles(16), .WakeOnIntEn(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n_v[3]), .wake_int_i(wake_d), .soft_rst_req_i(soft_d),
    .hart_if(if_d), .ready_o(ready_d), .state_o(state_d));

  cva6_tile_rst_ctrl #(.NrHarts(2), .WakeCycles(16), .SoftRstCycles(16)) u_e (
    .clk_i(clk), .rst_ni(rst_n_v[4]), .wake_int_i(wake_e), .soft_rst_req_i(soft_e),
    .hart_if(if_e), .ready_o(ready_e), .state_o(state_e));

  logic [15:0] obs [5];
  always_comb begin
    obs[0] = 16'({if_a.irq_o, ready_a, if_a.hart_rst_no, state_a});
    obs[1] = 16'({state_b, ready_b, if_b.hart_rst_no});
    obs[2] = 16'({ready_c, if_c.hart_rst_no, state_c});
    obs[3] = 16'({ready_d, if_d.hart_rst_no, state_d});
    obs[4] = 16'({if_e.debug_req_o, state_e, ready_e, if_e.hart_rst_no});
  end

  int    e_cnt [5] = '{default: 0};
  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  sb_q [5][$];
  logic [15:0] prev [5];
  string names [5] = '{"a_default", "b_stagger", "c_early_int", "d_wait_int", "e_soft_rst"};

  // Edge number since the last reset release of each instance (E1 = first edge).
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      e_cnt[i] <= rst_n_v[i] ? e_cnt[i] + 1 : 0;
    end
  end

  // Monitor: every output change must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (!rst_n_v[i]) begin
        prev[i] = obs[i];
      end else if (obs[i] !== prev[i]) begin
        n_chk++;
        if (sb_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL %s: unexpected change at E%0d, got 0x%0h, expected it to stay 0x%0h",
                   names[i], e_cnt[i], obs[i], prev[i]);
        end else begin
          e = sb_q[i].pop_front();
          if ((e.edge_n != e_cnt[i]) || (e.val !== obs[i])) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h at E%0d, expected 0x%0h at E%0d",
                     names[i], obs[i], e_cnt[i], e.val, e.edge_n);
          end
        end
        prev[i] = obs[i];
      end
    end
  end

  task automatic push(input int id, input int n, input logic [15:0] v);
    exp_t e;
    e.edge_n = n;
    e.val    = v;
    sb_q[id].push_back(e);
  endtask

  task automatic check_zero(input string name, input logic [63:0] got);
    n_chk++;
    if (got !== 64'd0) begin
      n_fail++;
      $display("FAIL %s: outputs 0x%0h, expected 0", name, got);
    end
  endtask

  // Returns at the falling edge that follows edge En of instance id.
  task automatic wait_e(input int id, input int n);
    @(negedge clk);
    while (e_cnt[id] < n) @(negedge clk);
  endtask

  function automatic logic [63:0] all_b();
    return 64'({if_b.irq_o, if_b.ipi_o, if_b.time_irq_o, if_b.debug_req_o,
                if_b.hart_rst_no, ready_b, state_b});
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    {wake_a, wake_b, wake_c, wake_d, wake_e} = '0;
    soft_a = '0; soft_b = '0; soft_c = '0; soft_d = '0; soft_e = '0;
    if_a.irq_i = 2'b11; if_a.ipi_i = '0; if_a.time_irq_i = '0; if_a.debug_req_i = '0;
    if_b.irq_i = '1;    if_b.ipi_i = '1; if_b.time_irq_i = '1; if_b.debug_req_i = '1;
    if_c.irq_i = '0;    if_c.ipi_i = '0; if_c.time_irq_i = '0; if_c.debug_req_i = '0;
    if_d.irq_i = '0;    if_d.ipi_i = '0; if_d.time_irq_i = '0; if_d.debug_req_i = '0;
    if_e.irq_i = '0;    if_e.ipi_i = '0; if_e.time_irq_i = '0; if_e.debug_req_i = 2'b10;

    #2 rst_n_v = '0;
    #1;
    check_zero("a_reset", 64'({if_a.irq_o, if_a.ipi_o, if_a.time_irq_o, if_a.debug_req_o,
                               if_a.hart_rst_no, ready_a, state_a}));
    check_zero("b_reset", all_b());
    check_zero("c_reset", 64'({if_c.irq_o, if_c.hart_rst_no, ready_c, state_c}));
    check_zero("d_reset", 64'({if_d.irq_o, if_d.hart_rst_no, ready_d, state_d}));
    check_zero("e_reset", 64'({if_e.irq_o, if_e.ipi_o, if_e.time_irq_o, if_e.debug_req_o,
                               if_e.hart_rst_no, ready_e, state_e}));

    // Expectations for the first sequence of every instance.
    push(0, 32768, 16'h02); push(0, 32769, 16'h03);
    push(0, 32771, 16'h0F); push(0, 32782, 16'h3F);
    push(1, 16, 16'h40);    push(1, 19, 16'h41);
    push(2, 16, 16'h2);     push(2, 17, 16'h3);     push(2, 19, 16'hF);
    push(3, 16, 16'h1);     push(3, 40, 16'h2);     push(3, 41, 16'h3);  push(3, 43, 16'hF);
    push(4, 16, 16'h10);    push(4, 18, 16'h18);    push(4, 19, 16'h19); push(4, 20, 16'h5F);

    @(negedge clk);
    rst_n_v = '1;

    fork
      begin : seq_a
        wait_e(0, 32000); if_a.irq_i = 2'b00;
        wait_e(0, 32780); if_a.irq_i = 2'b11;
        wait_e(0, 32790);
      end
      begin : seq_b
        wait_e(1, 22);
        #2 rst_n_v[1] = 1'b0;
        #1 check_zero("b_reset_mid_release", all_b());
        repeat (3) @(negedge clk);
        push(1, 16, 16'h40); push(1, 19, 16'h41); push(1, 23, 16'h43);
        push(1, 27, 16'h47); push(1, 29, 16'h67); push(1, 31, 16'h7F);
        rst_n_v[1] = 1'b1;
        wait_e(1, 40);
      end
      begin : seq_c
        wait_e(2, 4); wake_c = 1'b1;
        wait_e(2, 5); wake_c = 1'b0;
        wait_e(2, 25);
      end
      begin : seq_d
        wait_e(3, 39); wake_d = 1'b1;
        wait_e(3, 40); wake_d = 1'b0;
        wait_e(3, 50);
      end
      begin : seq_e
        // Request before release must be ignored.
        wait_e(4, 9);   soft_e = 2'b10;
        wait_e(4, 10);  soft_e = 2'b00;
        // Hart 1 soft reset at E100, re-requested at E110.
        wait_e(4, 99);  push(4, 100, 16'h19); soft_e = 2'b10;
        wait_e(4, 100); soft_e = 2'b00;
        wait_e(4, 109); push(4, 128, 16'h5F); soft_e = 2'b10;
        wait_e(4, 110); soft_e = 2'b00;
        // Single request at E200.
        wait_e(4, 199); push(4, 200, 16'h19); push(4, 218, 16'h5F); soft_e = 2'b10;
        wait_e(4, 200); soft_e = 2'b00;
        // Both harts at once at E300.
        wait_e(4, 299); push(4, 300, 16'h18); push(4, 318, 16'h5F); soft_e = 2'b11;
        wait_e(4, 300); soft_e = 2'b00;
        // debug_req_i[0] toggled every 5 cycles from E400.
        for (int k = 0; k < 7; k++) begin
          wait_e(4, 399 + 5 * k);
          if_e.debug_req_i[0] = ~if_e.debug_req_i[0];
          push(4, 401 + 5 * k, (k % 2 == 0) ? 16'h7F : 16'h5F);
        end
        wait_e(4, 440);
      end
    join

    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (sb_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL %s: %0d expected changes never seen, first due at E%0d value 0x%0h",
                 names[i], sb_q[i].size(), sb_q[i][0].edge_n, sb_q[i][0].val);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cva6_tile_rst_ctrl.md
# cva6_tile_rst_ctrl

Per-tile reset sequencer and interrupt synchroniser for multi-hart CVA6 tiles on the OpenPiton L1.5 NoC. It holds all harts in reset while tile SRAMs initialise, and can optionally also wait for the L1.5 wake-up interrupt. Harts are then released one at a time with a configurable stagger, and each hart can be soft-reset on its own. All asynchronous interrupt and debug lines are brought into `clk_i` and forced low while the owning hart is in reset.

## Interface
Parameters:
- `NrHarts`, 1, number of harts released by this block (1..8).
- `NrIrqLines`, 2, level interrupt lines per hart (mip/sip).
- `SyncStages`, 2, flops per synchroniser chain (>=2).
- `WakeCycles`, 32768, SRAM-init wait in cycles (1..2^20).
- `StaggerCycles`, 0, idle cycles between consecutive hart releases.
- `WakeOnIntEn`, 0, 1 = also require an L1.5 interrupt return before release.
- `SoftRstCycles`, 16, soft-reset hold length (>=1).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `wake_int_i`  in  1  L1.5 INT-return valid (synchronous to `clk_i`).
- `soft_rst_req_i`  in  NrHarts  one-cycle soft-reset request per hart.
- `irq_i`  in  NrHarts*NrIrqLines  async level IRQs; hart h uses bits [h*NrIrqLines +: NrIrqLines].
- `ipi_i`, `time_irq_i`, `debug_req_i`  in  NrHarts each  async.
- `hart_rst_no`  out  NrHarts  per-hart reset, active-low.
- `irq_o`  out  NrHarts*NrIrqLines  synchronised and gated IRQs.
- `ipi_o`, `time_irq_o`, `debug_req_o`  out  NrHarts each  synchronised and gated.
- `ready_o`  out  1  high when every hart is out of reset.
- `state_o`  out  2  FSM state (0 WAIT_SRAM, 1 WAIT_INT, 2 RELEASE, 3 RUN).

## Operation
- FSM states:
  - WAIT_SRAM: `wake_cnt_q` (width $clog2(WakeCycles+1)) increments each cycle and saturates. When `wake_cnt_q == WakeCycles-1`, the FSM goes to RELEASE if `!WakeOnIntEn`, `int_seen_q` or `wake_int_i` is true. Otherwise it goes to WAIT_INT.
  - WAIT_INT: goes to RELEASE on `wake_int_i`.
  - RELEASE: sets `rel_q[idx_q]`. If `idx_q == NrHarts-1` the FSM goes to RUN. Otherwise it loads `stag_cnt_q = StaggerCycles`, counts it down to 0, increments `idx_q`, and sets the next `rel_q` on the cycle after the counter reaches 0.
  - RUN: terminal state; only `rst_ni` leaves it.
- `int_seen_q` is a sticky flag set by any `wake_int_i` after reset, so an early interrupt is not lost.
- Per-hart reset chain:
  - `SyncStages` flops, shifting in `rel_q[h] & (soft_cnt_q[h] == 0)`.
  - `hart_rst_no[h]` is the last flop.
  - `rst_ni` clears the chain asynchronously.
- Soft reset:
  - Honoured only when `rel_q[h]` is set; ignored otherwise.
  - On request: load `soft_cnt_q[h] = SoftRstCycles` and clear all of hart h's chain flops synchronously on the same edge. The counter decrements each cycle until 0.
  - A request while the counter is non-zero reloads it.
  - Harts are independent; simultaneous requests from several harts are all honoured.
- Interrupt synchronisers:
  - Each async input has a `SyncStages` chain reset to 0.
  - Outputs are the chain output AND `hart_rst_no[h]`.
- `ready_o = &hart_rst_no`; it drops during any soft reset.

## Timing
- Reset values: all outputs 0; `state_o = 0`; all counters, `idx_q`, `rel_q` and `int_seen_q` are 0.
- Edge numbering: E1 is the first rising edge after `rst_ni` deasserts.
- Release timing with `WakeOnIntEn = 0`:
  - FSM enters RELEASE at EW (W = `WakeCycles`).
  - `rel_q[h]` sets at E(W+1+h*(StaggerCycles+1)).
  - `hart_rst_no[h]` rises SyncStages edges after its `rel_q` sets.
- With `WakeOnIntEn = 1` and no interrupt seen by EW: `rel_q[0]` sets one edge after the edge that samples `wake_int_i` in WAIT_INT.
- Soft reset timing:
  - Request sampled at edge Er: `hart_rst_no[h] = 0` and hart h's sync outputs are 0 after Er.
  - `hart_rst_no[h]` rises at E(r + SoftRstCycles + SyncStages).
- Interrupt path latency: SyncStages edges from a stable input to its output.
- `rst_ni` assertion at any time: outputs go to reset values asynchronously, and the sequence restarts from WAIT_SRAM.

## Test plan
- Defaults (NrHarts=1, W=32768, S=2): `hart_rst_no` rises at E32771 and `ready_o` at the same edge; `irq_i=2'b11` before that gives `irq_o=0`, and after it gives `irq_o=2'b11` two edges later.
- NrHarts=4, W=16, StaggerCycles=3: `hart_rst_no[0..3]` rise at E19, E23, E27, E31; `state_o` reaches 3 after E29.
- WakeOnIntEn=1, W=16:
  - `wake_int_i` pulsed at E5: release at E17, as with no wait.
  - No pulse: FSM holds in state 1; pulse sampled at E40 → `hart_rst_no` rises at E43.
- Soft reset, NrHarts=2, SoftRstCycles=16, in RUN:
  - Request hart 1 at E100: `hart_rst_no[1]` low after E100 and high at E118; hart 0 unaffected; `ready_o` low in between.
  - Re-request at E110: rise moves to E128.
  - Request before release: ignored.
- `rst_ni` asserted mid-RELEASE (after hart 1 of 4 released): all outputs are 0 immediately; after deassertion the full sequence repeats with the original timing.
- `debug_req_i` toggled every 5 cycles in RUN: `debug_req_o` follows with 2-cycle latency and no glitches.
